// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and helpers for the CNN datapath blocks.
// Bank/reader state encodings and the address-width helper.
package cnn_pkg;

    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_FILLING = 2'd1,
        B_FULL    = 2'd2,
        B_READING = 2'd3
    } bank_st_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_RUN   = 2'd2
    } rd_st_e;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// pp_bank_ram: one ping-pong bank, simple dual-port RAM with a
// LAT-stage registered read; each stage holds until new data arrives.
module pp_bank_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1568,
    parameter int LAT        = 1,
    parameter int AW         = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic                         re,
    input  logic [AW-1:0]                raddr,
    output logic signed [DATA_WIDTH-1:0] q,
    output logic                         qv
);

    logic signed [DATA_WIDTH-1:0] mem  [DEPTH];
    logic signed [DATA_WIDTH-1:0] pipe [LAT];
    logic [LAT-1:0]               vld;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            vld[0] <= re;
            if (re) begin
                pipe[0] <= mem[raddr];
            end
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    assign q  = pipe[LAT-1];
    assign qv = vld[LAT-1];

endmodule

// File: rtl/fc_pingpong_ctrl.sv
// fc_pingpong_ctrl: two-bank ping-pong input buffer feeding a dense layer.
// Define FC_PP_STATS_EN to build the frame and stall counters.
module fc_pingpong_ctrl
    import cnn_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  IN_DIM     = 1568,
    parameter int  LAT        = 1,
    localparam int AW         = addr_w(IN_DIM)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic                         wr_last,
    output logic                         dense_start,
    input  logic [AW-1:0]                dense_in_addr,
    input  logic                         dense_in_en,
    output logic signed [DATA_WIDTH-1:0] dense_in_q,
    input  logic                         dense_done,
    output logic                         frame_done,
    output logic                         busy,
    output logic                         err_len,
    output logic                         err_spurious,
    output logic [31:0]                  stat_frames,
    output logic [31:0]                  stat_stall
);

    localparam logic [AW-1:0] LAST = AW'(IN_DIM - 1);

    bank_st_e bst   [2];
    bank_st_e bst_n [2];
    rd_st_e   rstate;
    rd_st_e   rstate_n;

    logic          wsel;
    logic          wsel_n;
    logic          rsel;
    logic          rsel_n;
    logic [AW-1:0] wcnt;
    logic [AW-1:0] wcnt_n;
    logic          frame_done_n;
    logic          err_len_n;
    logic          err_sp_n;
    logic          wr_acc;
    logic          wr_end;
    logic          qsel;
    logic [1:0]    we;
    logic [1:0]    re;
    logic [1:0]    qv;

    logic signed [DATA_WIDTH-1:0] q [2];

    assign wr_ready = (bst[wsel] == B_EMPTY) ||
                      (bst[wsel] == B_FILLING);
    assign wr_acc   = wr_valid && wr_ready;
    assign wr_end   = (wcnt == LAST);
    assign busy     = (bst[0] != B_EMPTY) ||
                      (bst[1] != B_EMPTY) ||
                      (rstate != R_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            bst[0]       <= B_EMPTY;
            bst[1]       <= B_EMPTY;
            rstate       <= R_IDLE;
            wsel         <= 1'b0;
            rsel         <= 1'b0;
            wcnt         <= '0;
            frame_done   <= 1'b0;
            err_len      <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            bst[0]       <= bst_n[0];
            bst[1]       <= bst_n[1];
            rstate       <= rstate_n;
            wsel         <= wsel_n;
            rsel         <= rsel_n;
            wcnt         <= wcnt_n;
            frame_done   <= frame_done_n;
            err_len      <= err_len_n;
            err_spurious <= err_sp_n;
        end
    end

    // Writer and reader never own the same bank, so both updates apply.
    always_comb begin
        bst_n[0]     = bst[0];
        bst_n[1]     = bst[1];
        rstate_n     = rstate;
        wsel_n       = wsel;
        rsel_n       = rsel;
        wcnt_n       = wcnt;
        frame_done_n = 1'b0;
        err_len_n    = err_len;
        err_sp_n     = err_spurious;
        dense_start  = 1'b0;

        if (wr_acc) begin
            wcnt_n      = wcnt + AW'(1);
            bst_n[wsel] = B_FILLING;
            if (wr_last != wr_end) begin
                err_len_n = 1'b1;
            end
            if (wr_last || wr_end) begin
                bst_n[wsel] = B_FULL;
                wcnt_n      = '0;
                wsel_n      = ~wsel;
            end
        end

        unique case (rstate)
            R_IDLE: begin
                if (bst[rsel] == B_FULL) begin
                    bst_n[rsel] = B_READING;
                    rstate_n    = R_START;
                end
            end
            R_START: begin
                dense_start = 1'b1;
                rstate_n    = R_RUN;
            end
            R_RUN: begin
                if (dense_done) begin
                    bst_n[rsel]  = B_EMPTY;
                    rsel_n       = ~rsel;
                    frame_done_n = 1'b1;
                    rstate_n     = R_IDLE;
                end
            end
            default: begin
                rstate_n = R_IDLE;
            end
        endcase

        if (dense_done && (rstate != R_RUN)) begin
            err_sp_n = 1'b1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign we[b] = wr_acc && (wsel == 1'(b));
        assign re[b] = dense_in_en && (rstate == R_RUN) &&
                       (rsel == 1'(b));

        pp_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IN_DIM),
            .LAT        (LAT),
            .AW         (AW)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .we    (we[b]),
            .waddr (wcnt),
            .wdata (wr_data),
            .re    (re[b]),
            .raddr (dense_in_addr),
            .q     (q[b]),
            .qv    (qv[b])
        );
    end

    // rsel may flip while a read is in flight; track which bank spoke last.
    always_ff @(posedge clk) begin
        if (reset) begin
            qsel <= 1'b0;
        end else if (qv[0] || qv[1]) begin
            qsel <= qv[1];
        end
    end

    assign dense_in_q = qv[1] ? q[1] :
                        qv[0] ? q[0] :
                        qsel  ? q[1] : q[0];

`ifdef FC_PP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_frames <= '0;
            stat_stall  <= '0;
        end else begin
            if (frame_done && (stat_frames != '1)) begin
                stat_frames <= stat_frames + 32'd1;
            end
            if (wr_valid && !wr_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`else
    assign stat_frames = '0;
    assign stat_stall  = '0;
`endif

endmodule
